skinny_core_ctrl: RTL and testbench

- Iterative SKINNY-128-384+ encryption engine for the Romulus datapath.
- Registers the state, TK3 (key), TK2 (tweak) and TK1 (counter), then repeatedly drives the unrolled combinational round stage `skinny_rnd`.
- Generates the packed 6-bit round-constant vector for each pass and sequences the 40 rounds.
- Exposes valid/ready handshakes on both the input and the output side.

---
 rtl/skinny_core_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_skinny_core_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/skinny_core_ctrl.sv
// SKINNY-128-384+ iterative engine: unrolled round stage plus a
// 40-round sequencer with valid/ready handshakes on both sides.

module skinny_rnd #(
  parameter int numrnd  = 2,
  parameter int fullcnt = 1
) (
  input  logic [127:0]           state,
  input  logic [127:0]           key,
  input  logic [127:0]           tweak,
  input  logic [63+64*fullcnt:0] cnt,
  input  logic [6*numrnd-1:0]    rc,
  input  logic                   odd,
  output logic [127:0]           nextstate,
  output logic [127:0]           nextkey,
  output logic [127:0]           nexttweak,
  output logic [63+64*fullcnt:0] nextcnt
);
  localparam int CW = 64 + 64 * fullcnt;
  localparam logic [63:0] SR = 64'h0123_7456_ab89_defc;
  localparam logic [63:0] PT = 64'h9f8d_aecb_0123_4567;

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = a;
    for (int i = 0; i < 4; i++) begin
      x[4] = x[4] ^ ~(x[7] | x[6]);
      x[0] = x[0] ^ ~(x[3] | x[2]);
      if (i < 3)
        x = {x[2], x[1], x[7], x[6],
             x[4], x[0], x[3], x[5]};
    end
    return {x[7:3], x[1], x[2], x[0]};
  endfunction

  // p holds one source-byte nibble per byte, byte 0 first
  function automatic logic [127:0] bperm(
    input logic [127:0] v,
    input logic [63:0]  p
  );
    logic [127:0] r;
    int           src;
    r = '0;
    for (int b = 0; b < 16; b++) begin
      src = int'(p[4*(15-b) +: 4]);
      r[8*(15-b) +: 8] = v[8*(15-src) +: 8];
    end
    return r;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] v);
    return {v[127:96] ^ v[63:32] ^ v[31:0],
            v[127:96],
            v[95:64] ^ v[63:32],
            v[127:96] ^ v[63:32]};
  endfunction

  function automatic logic [63:0] lfsr2(input logic [63:0] v);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < 8; b++)
      r[8*b +: 8] = {v[8*b +: 7], v[8*b+7] ^ v[8*b+5]};
    return r;
  endfunction

  function automatic logic [63:0] lfsr3(input logic [63:0] v);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < 8; b++)
      r[8*b +: 8] = {v[8*b] ^ v[8*b+6], v[8*b+1 +: 7]};
    return r;
  endfunction

  // Short TK1 keeps only its live half in the top bytes; odd
  // rounds see that half parked in the bottom rows (no XOR).
  always_comb begin
    logic [127:0] s, k1, k2, k3, tk;
    s  = state;
    k3 = key;
    k2 = tweak;
    k1 = '0;
    k1[127 -: CW] = cnt;
    tk = '0;
    for (int r = 0; r < numrnd; r++) begin
      if (fullcnt != 0) begin
        tk = k1;
        k1 = bperm(k1, PT);
      end else if (odd ^ (r % 2 == 1)) begin
        tk = '0;
        k1 = bperm({64'h0, k1[127:64]}, PT);
      end else begin
        tk = k1;
      end
      for (int b = 0; b < 16; b++)
        s[8*b +: 8] = sbox(s[8*b +: 8]);
      s[123:120] = s[123:120] ^ rc[6*r +: 4];
      s[89:88]   = s[89:88] ^ rc[6*r+4 +: 2];
      s[57]      = ~s[57];
      s[127:64]  = s[127:64] ^ tk[127:64]
                 ^ k2[127:64] ^ k3[127:64];
      s  = mix(bperm(s, SR));
      k2 = bperm(k2, PT);
      k3 = bperm(k3, PT);
      k2[127:64] = lfsr2(k2[127:64]);
      k3[127:64] = lfsr3(k3[127:64]);
    end
    nextstate = s;
    nextkey   = k3;
    nexttweak = k2;
    nextcnt   = k1[127 -: CW];
  end
endmodule

module skinny_core_ctrl #(
  parameter int numrnd  = 2,
  parameter int fullcnt = 1,
  parameter int nrounds = 40
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [127:0]           pt,
  input  logic [127:0]           key,
  input  logic [127:0]           tweak,
  input  logic [63+64*fullcnt:0] cnt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [127:0]           ct,
  output logic                   busy
);
  localparam int CW   = 64 + 64 * fullcnt;
  localparam int LAST = nrounds / numrnd - 1;

  if (numrnd < 1 || nrounds % numrnd != 0) begin : g_bad
    $error("numrnd must divide nrounds");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  fsm_e                fsm_q, fsm_d;
  logic [127:0]        st_q, st_d;
  logic [127:0]        tk3_q, tk3_d;
  logic [127:0]        tk2_q, tk2_d;
  logic [CW-1:0]       tk1_q, tk1_d;
  logic [5:0]          rc_q, rc_d;
  logic [5:0]          rcnt_q, rcnt_d;
  logic [6*numrnd-1:0] rc_vec;
  logic [127:0]        nst, nkey, ntw;
  logic [CW-1:0]       ncnt;
  logic                odd;

  assign odd = (numrnd % 2 == 1) && rcnt_q[0];

  always_comb begin
    logic [5:0] c;
    c = rc_q;
    rc_vec = '0;
    for (int i = 0; i < numrnd; i++) begin
      c = {c[4:0], c[5] ^ c[4] ^ 1'b1};
      rc_vec[6*i +: 6] = c;
    end
  end

  skinny_rnd #(
    .numrnd  (numrnd),
    .fullcnt (fullcnt)
  ) u_rnd (
    .state     (st_q),
    .key       (tk3_q),
    .tweak     (tk2_q),
    .cnt       (tk1_q),
    .rc        (rc_vec),
    .odd       (odd),
    .nextstate (nst),
    .nextkey   (nkey),
    .nexttweak (ntw),
    .nextcnt   (ncnt)
  );

  always_comb begin
    fsm_d  = fsm_q;
    st_d   = st_q;
    tk3_d  = tk3_q;
    tk2_d  = tk2_q;
    tk1_d  = tk1_q;
    rc_d   = rc_q;
    rcnt_d = rcnt_q;
    unique case (fsm_q)
      IDLE: if (in_valid) begin
        st_d   = pt;
        tk3_d  = key;
        tk2_d  = tweak;
        tk1_d  = cnt;
        rc_d   = '0;
        rcnt_d = '0;
        fsm_d  = RUN;
      end
      RUN: begin
        st_d   = nst;
        tk3_d  = nkey;
        tk2_d  = ntw;
        tk1_d  = ncnt;
        rc_d   = rc_vec[6*numrnd-1 -: 6];
        rcnt_d = rcnt_q + 6'd1;
        if (rcnt_q == 6'(LAST)) fsm_d = DONE;
      end
      DONE: if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= IDLE;
      st_q   <= '0;
      tk3_q  <= '0;
      tk2_q  <= '0;
      tk1_q  <= '0;
      rc_q   <= '0;
      rcnt_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      st_q   <= st_d;
      tk3_q  <= tk3_d;
      tk2_q  <= tk2_d;
      tk1_q  <= tk1_d;
      rc_q   <= rc_d;
      rcnt_q <= rcnt_d;
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign busy      = (fsm_q == RUN);
  assign out_valid = (fsm_q == DONE);
  assign ct        = out_valid ? st_q : '0;
endmodule

// File: tb/tb_skinny_core_ctrl.sv
// Directed + random bench for skinny_core_ctrl against a
// byte-level SKINNY-128-384+ model, four parameter sets at once.

module tb_skinny_core_ctrl;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] pt, key, tweak, cnt;
  logic [3:0]   in_rdy, o_vld, bsy;
  logic [127:0] ct_o [4];

  int n_chk = 0;
  int n_err = 0;
  int exp_lat [4] = '{20, 40, 10, 8};

  logic [7:0] sb [256];
  logic [5:0] rcs [40];

  always #5 clk = ~clk;

  skinny_core_ctrl #(.numrnd(2), .fullcnt(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_rdy[0]),
    .pt(pt), .key(key), .tweak(tweak), .cnt(cnt),
    .out_valid(o_vld[0]), .out_ready(out_ready),
    .ct(ct_o[0]), .busy(bsy[0])
  );
  skinny_core_ctrl #(.numrnd(1), .fullcnt(0)) u_n1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_rdy[1]),
    .pt(pt), .key(key), .tweak(tweak), .cnt(cnt[127:64]),
    .out_valid(o_vld[1]), .out_ready(out_ready),
    .ct(ct_o[1]), .busy(bsy[1])
  );
  skinny_core_ctrl #(.numrnd(4), .fullcnt(1)) u_n4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_rdy[2]),
    .pt(pt), .key(key), .tweak(tweak), .cnt(cnt),
    .out_valid(o_vld[2]), .out_ready(out_ready),
    .ct(ct_o[2]), .busy(bsy[2])
  );
  skinny_core_ctrl #(.numrnd(5), .fullcnt(0)) u_n5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_rdy[3]),
    .pt(pt), .key(key), .tweak(tweak), .cnt(cnt[127:64]),
    .out_valid(o_vld[3]), .out_ready(out_ready),
    .ct(ct_o[3]), .busy(bsy[3])
  );

  function automatic logic [7:0] sbox_eval(input int v);
    int   dst [8] = '{2, 6, 7, 1, 3, 0, 4, 5};
    bit   b [8];
    bit   n [8];
    bit   tmp;
    logic [7:0] r;
    for (int i = 0; i < 8; i++) b[i] = v[i];
    for (int k = 0; k < 4; k++) begin
      b[4] = b[4] ^ !(b[7] | b[6]);
      b[0] = b[0] ^ !(b[3] | b[2]);
      if (k < 3) begin
        for (int i = 0; i < 8; i++) n[dst[i]] = b[i];
        b = n;
      end
    end
    tmp = b[1]; b[1] = b[2]; b[2] = tmp;
    for (int i = 0; i < 8; i++) r[i] = b[i];
    return r;
  endfunction

  function automatic logic [127:0] ref_enc(
    input logic [127:0] p, k, t, c
  );
    logic [7:0] s [16];
    logic [7:0] n [16];
    logic [7:0] t1 [16];
    logic [7:0] t2 [16];
    logic [7:0] t3 [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] res;
    int PT [16] = '{9, 15, 8, 13, 10, 14, 12, 11,
                    0, 1, 2, 3, 4, 5, 6, 7};
    for (int i = 0; i < 16; i++) begin
      s[i]  = p[127-8*i -: 8];
      t3[i] = k[127-8*i -: 8];
      t2[i] = t[127-8*i -: 8];
      t1[i] = c[127-8*i -: 8];
    end
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      s[0] = s[0] ^ {4'h0, rcs[r][3:0]};
      s[4] = s[4] ^ {6'h0, rcs[r][5:4]};
      s[8] = s[8] ^ 8'h02;
      for (int i = 0; i < 8; i++)
        s[i] = s[i] ^ t1[i] ^ t2[i] ^ t3[i];
      for (int rr = 0; rr < 4; rr++)
        for (int cc = 0; cc < 4; cc++)
          n[4*rr+cc] = s[4*rr + (cc + 4 - rr) % 4];
      s = n;
      for (int cc = 0; cc < 4; cc++) begin
        a0 = s[cc]; a1 = s[4+cc];
        a2 = s[8+cc]; a3 = s[12+cc];
        s[cc]    = a0 ^ a2 ^ a3;
        s[4+cc]  = a0;
        s[8+cc]  = a1 ^ a2;
        s[12+cc] = a0 ^ a2;
      end
      for (int i = 0; i < 16; i++) n[i] = t1[PT[i]];
      t1 = n;
      for (int i = 0; i < 16; i++) n[i] = t2[PT[i]];
      t2 = n;
      for (int i = 0; i < 16; i++) n[i] = t3[PT[i]];
      t3 = n;
      for (int i = 0; i < 8; i++) begin
        t2[i] = {t2[i][6:0], t2[i][7] ^ t2[i][5]};
        t3[i] = {t3[i][0] ^ t3[i][6], t3[i][7:1]};
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input logic [127:0] p, k, t, c,
                           input bit early, input int hold);
    logic [127:0] exp_ct [4];
    logic [127:0] cap [4];
    int           lat [4];
    logic [3:0]   seen;
    int           e;
    exp_ct[0] = ref_enc(p, k, t, c);
    exp_ct[2] = exp_ct[0];
    exp_ct[1] = ref_enc(p, k, t, {c[127:64], 64'h0});
    exp_ct[3] = exp_ct[1];
    seen = '0;
    for (int j = 0; j < 4; j++) begin
      lat[j] = 0;
      cap[j] = '0;
    end
    check("idle_ready", 128'(in_rdy), 128'hf);
    pt = p; key = k; tweak = t; cnt = c;
    in_valid = 1'b1;
    out_ready = early;
    step();
    in_valid = 1'b0;
    check("run_busy", 128'(bsy), 128'hf);
    check("run_in_ready", 128'(in_rdy), 128'h0);
    check("rc_first", 128'(u_dut.rc_vec),
          128'({rcs[1], rcs[0]}));
    e = 0;
    while (seen != 4'hf && e < 45) begin
      step();
      e++;
      pt = rnd128(); key = rnd128();
      tweak = rnd128(); cnt = rnd128();
      if (e == 19)
        check("rc_last", 128'(u_dut.rc_vec),
              128'({rcs[39], rcs[38]}));
      for (int j = 0; j < 4; j++)
        if (o_vld[j] && !seen[j]) begin
          seen[j] = 1'b1;
          lat[j]  = e;
          cap[j]  = ct_o[j];
        end
    end
    check("done_all", 128'(seen), 128'hf);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("latency%0d", j),
            128'(lat[j]), 128'(exp_lat[j]));
      check($sformatf("ct%0d", j), cap[j], exp_ct[j]);
    end
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        step();
        pt = rnd128();
        check("bp_valid", 128'(o_vld[0]), 128'd1);
        check("bp_ct", ct_o[0], cap[0]);
        check("bp_in_ready", 128'(in_rdy[0]), 128'd0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("release", 128'({in_rdy, o_vld}), 128'hf0);
    end else begin
      step();
      out_ready = 1'b0;
      check("early_release", 128'({in_rdy, o_vld}), 128'hf0);
    end
  endtask

  initial begin
    logic [5:0] r;
    logic [3:0] stale;
    r = '0;
    for (int i = 0; i < 40; i++) begin
      r = {r[4:0], r[5] ^ r[4] ^ 1'b1};
      rcs[i] = r;
    end
    for (int v = 0; v < 256; v++) sb[v] = sbox_eval(v);

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    pt = '0; key = '0; tweak = '0; cnt = '0;
    step();
    step();
    check("reset_state", 128'({in_rdy, o_vld, bsy}), 128'hf00);
    check("reset_ct", ct_o[0], 128'h0);
    #3 rst_n = 1'b1;
    step();

    run_block(128'h00112233_44556677_8899aabb_ccddeeff,
              128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0,
              128'h01234567_89abcdef_fedcba98_76543210,
              128'hdeadbeef_00000001_00000000_0000004f,
              1'b0, 10);

    pt = rnd128(); key = rnd128();
    tweak = rnd128(); cnt = rnd128();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    check("mid_rcnt", 128'(u_dut.rcnt_q), 128'd7);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", 128'({in_rdy, o_vld, bsy}), 128'hf00);
    check("async_rst_ct", ct_o[0], 128'h0);
    check("async_rst_st", u_dut.st_q, 128'h0);
    #1 rst_n = 1'b1;
    stale = '0;
    repeat (30) begin
      step();
      stale = stale | o_vld;
    end
    check("no_stale_valid", 128'(stale), 128'h0);

    run_block(128'hffffffff_ffffffff_ffffffff_ffffffff,
              128'h0, 128'h80000000_00000000_00000000_00000001,
              128'h00000000_00000000_ffffffff_ffffffff,
              1'b0, 0);

    for (int i = 0; i < 100; i++)
      run_block(rnd128(), rnd128(), rnd128(), rnd128(),
                i[0], i % 3);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
